// File: rtl/riscv_wb.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_wb
//  Purpose  : Write-back stage. Retires ALU/CSR results with one-cycle
//             latency, waits for load responses, then aligns and extends the
//             data onto the registered register-file write port. Load bus
//             errors raise a one-cycle exception pulse with the faulting
//             address. Optional load watchdog: define WB_LOAD_TIMEOUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module riscv_wb #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            mem_valid_i,
  input  logic [4:0]      mem_rd_i,
  input  logic [XLEN-1:0] mem_r_i,
  input  logic [XLEN-1:0] mem_addr_i,
  input  logic            mem_is_load_i,
  input  logic [1:0]      mem_size_i,
  input  logic            mem_unsigned_i,
  input  logic            wb_flush_i,
  input  logic            dmem_ack_i,
  input  logic            dmem_err_i,
  input  logic [XLEN-1:0] dmem_q_i,
  output logic            wb_stall_o,
  output logic [4:0]      rf_dst_o,
  output logic [XLEN-1:0] rf_dst_d_o,
  output logic            rf_we_o,
  output logic            wb_exception_o,
  output logic [XLEN-1:0] wb_badaddr_o
);

  localparam logic [1:0] c_IDLE = 2'd0;  // accepting
  localparam logic [1:0] c_WAIT = 2'd1;  // load outstanding
  localparam logic [1:0] c_KILL = 2'd2;  // flushed load, response discarded

  logic [1:0]      r_state;
  logic [4:0]      r_rd;
  logic [1:0]      r_size;
  logic            r_uns;
  logic [XLEN-1:0] r_addr;

  logic            w_accept;
  logic            w_timeout;
  logic [XLEN-1:0] w_shifted;
  logic [XLEN-1:0] w_load_data;

  assign w_accept   = (r_state == c_IDLE) && mem_valid_i && !wb_flush_i;
  // Derived from registered state only, so there is no path from dmem_ack_i.
  assign wb_stall_o = (r_state != c_IDLE);

  // Align the raw load word by the byte offset and sign/zero-extend.
  always_comb begin
    w_shifted = dmem_q_i >> {r_addr[1:0], 3'b000};
    case (r_size)
      2'b00:   w_load_data = r_uns ? {{(XLEN-8){1'b0}}, w_shifted[7:0]}
                                   : {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
      2'b01:   w_load_data = r_uns ? {{(XLEN-16){1'b0}}, w_shifted[15:0]}
                                   : {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
      default: w_load_data = w_shifted;  // word, and size 11 treated as word
    endcase
  end

`ifdef WB_LOAD_TIMEOUT_EN
  localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT_CYCLES);

  logic [15:0] r_tmo_cnt;

  // Watchdog: fires when the count of ack-less cycles would reach the limit.
  assign w_timeout = (r_state != c_IDLE) && !dmem_ack_i &&
                     ((r_tmo_cnt + 16'd1) == c_TIMEOUT);

  // Count ack-less cycles; restart on entry to WAIT and on entry to KILL.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tmo_cnt <= '0;
    end else if (w_accept && mem_is_load_i) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == c_WAIT) && wb_flush_i && !dmem_ack_i) begin
      r_tmo_cnt <= '0;
    end else if ((r_state != c_IDLE) && !dmem_ack_i) begin
      r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Stage sequencing, load context capture and the registered RF/exception ports.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state        <= c_IDLE;
      r_rd           <= '0;
      r_size         <= '0;
      r_uns          <= 1'b0;
      r_addr         <= '0;
      rf_we_o        <= 1'b0;
      rf_dst_o       <= '0;
      rf_dst_d_o     <= '0;
      wb_exception_o <= 1'b0;
      wb_badaddr_o   <= '0;
    end else begin
      rf_we_o        <= 1'b0;
      wb_exception_o <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            if (mem_is_load_i) begin
              r_rd    <= mem_rd_i;
              r_size  <= mem_size_i;
              r_uns   <= mem_unsigned_i;
              r_addr  <= mem_addr_i;
              r_state <= c_WAIT;
            end else begin
              rf_we_o    <= (mem_rd_i != 5'd0);
              rf_dst_o   <= mem_rd_i;
              rf_dst_d_o <= mem_r_i;
            end
          end
        end
        c_WAIT: begin
          if (wb_flush_i) begin
            // A response arriving with the flush is simply dropped.
            r_state <= dmem_ack_i ? c_IDLE : c_KILL;
          end else if (dmem_ack_i && !dmem_err_i) begin
            rf_we_o    <= (r_rd != 5'd0);
            rf_dst_o   <= r_rd;
            rf_dst_d_o <= w_load_data;
            r_state    <= c_IDLE;
          end else if (dmem_ack_i || w_timeout) begin
            wb_exception_o <= 1'b1;
            wb_badaddr_o   <= r_addr;
            r_state        <= c_IDLE;
          end
        end
        c_KILL: begin
          if (dmem_ack_i || dmem_err_i || w_timeout) begin
            r_state <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_wb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_wb
//  Purpose  : Self-checking bench for riscv_wb: directed vector table,
//             hand-written multi-cycle sequences and a randomized run
//             against a behavioural reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_riscv_wb;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        mem_valid_i, mem_is_load_i, mem_unsigned_i, wb_flush_i;
  logic [4:0]  mem_rd_i;
  logic [31:0] mem_r_i, mem_addr_i, dmem_q_i;
  logic [1:0]  mem_size_i;
  logic        dmem_ack_i, dmem_err_i;
  logic        wb_stall_o, rf_we_o, wb_exception_o;
  logic [4:0]  rf_dst_o;
  logic [31:0] rf_dst_d_o, wb_badaddr_o;

  always #5 clk_i = ~clk_i;

  riscv_wb dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .mem_valid_i(mem_valid_i), .mem_rd_i(mem_rd_i), .mem_r_i(mem_r_i),
    .mem_addr_i(mem_addr_i), .mem_is_load_i(mem_is_load_i),
    .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i),
    .wb_flush_i(wb_flush_i), .dmem_ack_i(dmem_ack_i), .dmem_err_i(dmem_err_i),
    .dmem_q_i(dmem_q_i), .wb_stall_o(wb_stall_o), .rf_dst_o(rf_dst_o),
    .rf_dst_d_o(rf_dst_d_o), .rf_we_o(rf_we_o),
    .wb_exception_o(wb_exception_o), .wb_badaddr_o(wb_badaddr_o)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    mem_valid_i = 0; mem_rd_i = 0; mem_r_i = 0; mem_addr_i = 0;
    mem_is_load_i = 0; mem_size_i = 0; mem_unsigned_i = 0; wb_flush_i = 0;
    dmem_ack_i = 0; dmem_err_i = 0; dmem_q_i = 0;
  endtask

  task automatic present(input logic ld, input logic [4:0] rd, input logic [31:0] r,
                         input logic [31:0] addr, input logic [1:0] sz, input logic uns);
    mem_valid_i = 1; mem_is_load_i = ld; mem_rd_i = rd; mem_r_i = r;
    mem_addr_i = addr; mem_size_i = sz; mem_unsigned_i = uns;
  endtask

  // Spec-level load result: pick the addressed byte/half and extend it.
  function automatic logic [31:0] load_value(input logic [31:0] q, input logic [31:0] a,
                                             input logic [1:0] sz, input logic uns);
    longint v;
    int unsigned off;
    off = a[1:0];
    v = q;
    if (sz == 2'd0) begin
      v = (q >> (8 * off)) & 32'hFF;
      if (!uns && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      v = (q >> (8 * off)) & 32'hFFFF;
      if (!uns && v >= 32768) v = v - 65536;
    end
    return v[31:0];
  endfunction

  typedef struct {
    logic        ld;
    logic [4:0]  rd;
    logic [31:0] r;
    logic [31:0] addr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] q;
    logic        err;
    int          wait_n;
    logic        exp_we;
    logic [31:0] exp_d;
    logic        exp_exc;
  } vec_t;

  vec_t tbl[12];

  // Reference model state for the randomized run.
  bit          m_busy, m_kill;
  logic [4:0]  m_rd;
  logic [31:0] m_addr;
  logic [1:0]  m_sz;
  logic        m_uns;

  initial begin
    logic        e_we, e_exc;
    logic [4:0]  e_dst;
    logic [31:0] e_d, e_bad;
    logic [31:0] a;
    int          to;

    tbl[0]  = '{1'b0, 5'd5,  32'h11,  32'h0,    2'd0, 1'b0, 32'h0,         1'b0, 0, 1'b1, 32'h0000_0011, 1'b0};
    tbl[1]  = '{1'b1, 5'd3,  32'h0,   32'h1003, 2'd0, 1'b0, 32'h80FF_1234, 1'b0, 3, 1'b1, 32'hFFFF_FF80, 1'b0};
    tbl[2]  = '{1'b1, 5'd3,  32'h0,   32'h1003, 2'd0, 1'b1, 32'h80FF_1234, 1'b0, 3, 1'b1, 32'h0000_0080, 1'b0};
    tbl[3]  = '{1'b1, 5'd4,  32'h0,   32'h1002, 2'd1, 1'b0, 32'h80FF_1234, 1'b0, 1, 1'b1, 32'hFFFF_80FF, 1'b0};
    tbl[4]  = '{1'b1, 5'd4,  32'h0,   32'h1002, 2'd1, 1'b1, 32'h80FF_1234, 1'b0, 0, 1'b1, 32'h0000_80FF, 1'b0};
    tbl[5]  = '{1'b1, 5'd31, 32'h0,   32'h1000, 2'd2, 1'b0, 32'h80FF_1234, 1'b0, 2, 1'b1, 32'h80FF_1234, 1'b0};
    tbl[6]  = '{1'b1, 5'd8,  32'h0,   32'h1000, 2'd0, 1'b0, 32'h80FF_1234, 1'b0, 0, 1'b1, 32'h0000_0034, 1'b0};
    tbl[7]  = '{1'b1, 5'd8,  32'h0,   32'h1001, 2'd0, 1'b0, 32'h80FF_1234, 1'b0, 1, 1'b1, 32'h0000_0012, 1'b0};
    tbl[8]  = '{1'b1, 5'd8,  32'h0,   32'h1002, 2'd0, 1'b0, 32'h80FF_1234, 1'b0, 1, 1'b1, 32'hFFFF_FFFF, 1'b0};
    tbl[9]  = '{1'b1, 5'd6,  32'h0,   32'h2000, 2'd2, 1'b0, 32'hDEAD_BEEF, 1'b1, 2, 1'b0, 32'h0,         1'b1};
    tbl[10] = '{1'b1, 5'd6,  32'h0,   32'h1000, 2'd3, 1'b0, 32'h80FF_1234, 1'b0, 0, 1'b1, 32'h80FF_1234, 1'b0};
    tbl[11] = '{1'b1, 5'd0,  32'h0,   32'h1000, 2'd1, 1'b0, 32'h0000_8001, 1'b0, 1, 1'b0, 32'h0,         1'b0};

    clear_inputs();
    rst_ni = 0;
    tick(); tick();
    chk("reset_we", {31'b0, rf_we_o}, 32'd0);
    chk("reset_dst", {27'b0, rf_dst_o}, 32'd0);
    chk("reset_data", rf_dst_d_o, 32'd0);
    chk("reset_exc", {31'b0, wb_exception_o}, 32'd0);
    chk("reset_bad", wb_badaddr_o, 32'd0);
    chk("reset_stall", {31'b0, wb_stall_o}, 32'd0);
    rst_ni = 1;
    tick();

    // Directed single transactions from the table.
    for (int i = 0; i < 12; i++) begin
      present(tbl[i].ld, tbl[i].rd, tbl[i].r, tbl[i].addr, tbl[i].sz, tbl[i].uns);
      tick();
      mem_valid_i = 0;
      if (tbl[i].ld) begin
        for (int w = 0; w < tbl[i].wait_n; w++) begin
          chk($sformatf("vec%0d_wait_stall", i), {31'b0, wb_stall_o}, 32'd1);
          chk($sformatf("vec%0d_wait_we", i), {31'b0, rf_we_o}, 32'd0);
          tick();
        end
        chk($sformatf("vec%0d_ack_stall", i), {31'b0, wb_stall_o}, 32'd1);
        dmem_ack_i = 1; dmem_err_i = tbl[i].err; dmem_q_i = tbl[i].q;
        tick();
        dmem_ack_i = 0; dmem_err_i = 0;
      end
      chk($sformatf("vec%0d_we", i), {31'b0, rf_we_o}, {31'b0, tbl[i].exp_we});
      if (tbl[i].exp_we) begin
        chk($sformatf("vec%0d_dst", i), {27'b0, rf_dst_o}, {27'b0, tbl[i].rd});
        chk($sformatf("vec%0d_data", i), rf_dst_d_o, tbl[i].exp_d);
      end
      chk($sformatf("vec%0d_exc", i), {31'b0, wb_exception_o}, {31'b0, tbl[i].exp_exc});
      if (tbl[i].exp_exc) chk($sformatf("vec%0d_bad", i), wb_badaddr_o, tbl[i].addr);
      chk($sformatf("vec%0d_stall_after", i), {31'b0, wb_stall_o}, 32'd0);
      tick();
      chk($sformatf("vec%0d_we_pulse", i), {31'b0, rf_we_o}, 32'd0);
      chk($sformatf("vec%0d_exc_pulse", i), {31'b0, wb_exception_o}, 32'd0);
    end

    // Back-to-back non-loads, the middle one targets x0.
    present(0, 5'd5, 32'h11, 0, 0, 0); tick();
    chk("b2b0_we", {31'b0, rf_we_o}, 32'd1);
    chk("b2b0_dst", {27'b0, rf_dst_o}, 32'd5);
    chk("b2b0_data", rf_dst_d_o, 32'h11);
    present(0, 5'd0, 32'h22, 0, 0, 0); tick();
    chk("b2b1_we", {31'b0, rf_we_o}, 32'd0);
    present(0, 5'd7, 32'h33, 0, 0, 0); tick();
    chk("b2b2_we", {31'b0, rf_we_o}, 32'd1);
    chk("b2b2_dst", {27'b0, rf_dst_o}, 32'd7);
    chk("b2b2_data", rf_dst_d_o, 32'h33);
    mem_valid_i = 0; tick();

    // Flush while idle suppresses acceptance.
    present(0, 5'd3, 32'h99, 0, 0, 0); wb_flush_i = 1; tick();
    mem_valid_i = 0; wb_flush_i = 0;
    chk("idle_flush_we", {31'b0, rf_we_o}, 32'd0);

    // Ack while idle is ignored.
    dmem_ack_i = 1; dmem_err_i = 1; tick();
    dmem_ack_i = 0; dmem_err_i = 0;
    chk("idle_ack_we", {31'b0, rf_we_o}, 32'd0);
    chk("idle_ack_exc", {31'b0, wb_exception_o}, 32'd0);

    // Flush in WAIT, ack two cycles later, then immediate acceptance.
    present(1, 5'd9, 0, 32'h3000, 2'd2, 0); tick();
    mem_valid_i = 0; wb_flush_i = 1; tick();
    wb_flush_i = 0;
    chk("kill_stall", {31'b0, wb_stall_o}, 32'd1);
    tick();
    chk("kill_stall2", {31'b0, wb_stall_o}, 32'd1);
    dmem_ack_i = 1; dmem_q_i = 32'h1234_5678; tick();
    dmem_ack_i = 0;
    chk("kill_we", {31'b0, rf_we_o}, 32'd0);
    chk("kill_exc", {31'b0, wb_exception_o}, 32'd0);
    chk("kill_stall_after", {31'b0, wb_stall_o}, 32'd0);
    present(0, 5'd4, 32'h44, 0, 0, 0); tick();
    mem_valid_i = 0;
    chk("kill_next_we", {31'b0, rf_we_o}, 32'd1);
    chk("kill_next_data", rf_dst_d_o, 32'h44);

    // Flush on the same cycle as the ack discards the response.
    present(1, 5'd10, 0, 32'h3004, 2'd2, 0); tick();
    mem_valid_i = 0; wb_flush_i = 1; dmem_ack_i = 1; dmem_err_i = 1; tick();
    wb_flush_i = 0; dmem_ack_i = 0; dmem_err_i = 0;
    chk("flush_ack_we", {31'b0, rf_we_o}, 32'd0);
    chk("flush_ack_exc", {31'b0, wb_exception_o}, 32'd0);
    chk("flush_ack_stall", {31'b0, wb_stall_o}, 32'd0);

    // Asynchronous reset while a load is outstanding.
    present(1, 5'd11, 0, 32'h4000, 2'd2, 0); tick();
    mem_valid_i = 0;
    chk("rst_pre_stall", {31'b0, wb_stall_o}, 32'd1);
    #2 rst_ni = 0;
    #1;
    chk("async_rst_stall", {31'b0, wb_stall_o}, 32'd0);
    chk("async_rst_we", {31'b0, rf_we_o}, 32'd0);
    chk("async_rst_dst", {27'b0, rf_dst_o}, 32'd0);
    chk("async_rst_data", rf_dst_d_o, 32'd0);
    chk("async_rst_bad", wb_badaddr_o, 32'd0);
    tick();
    rst_ni = 1;
    tick();
    dmem_ack_i = 1; dmem_q_i = 32'hCAFE_F00D; tick();
    dmem_ack_i = 0;
    chk("post_rst_ack_we", {31'b0, rf_we_o}, 32'd0);
    chk("post_rst_ack_stall", {31'b0, wb_stall_o}, 32'd0);

    // Randomized traffic against the reference model.
    m_busy = 0; m_kill = 0; m_rd = 0; m_addr = 0; m_sz = 0; m_uns = 0;
    e_dst = 0; e_d = 0; e_bad = 0;
    for (int c = 0; c < 600; c++) begin
      a = $urandom;
      mem_size_i = 2'($urandom_range(0, 3));
      if (mem_size_i == 2'd1) a[0] = 1'b0;
      if (mem_size_i[1]) a[1:0] = 2'b00;
      mem_addr_i = a;
      mem_valid_i = ($urandom_range(0, 1) == 1);
      mem_is_load_i = ($urandom_range(0, 1) == 1);
      mem_rd_i = 5'($urandom_range(0, 31));
      mem_r_i = $urandom;
      mem_unsigned_i = ($urandom_range(0, 1) == 1);
      wb_flush_i = ($urandom_range(0, 9) == 0);
      dmem_ack_i = ($urandom_range(0, 9) < 3);
      dmem_err_i = ($urandom_range(0, 4) == 0);
      dmem_q_i = $urandom;

      e_we = 0; e_exc = 0;
      if (!m_busy) begin
        if (mem_valid_i && !wb_flush_i) begin
          if (mem_is_load_i) begin
            m_busy = 1; m_kill = 0; m_rd = mem_rd_i; m_addr = mem_addr_i;
            m_sz = mem_size_i; m_uns = mem_unsigned_i;
          end else begin
            e_we = (mem_rd_i != 0); e_dst = mem_rd_i; e_d = mem_r_i;
          end
        end
      end else if (m_kill) begin
        if (dmem_ack_i || dmem_err_i) m_busy = 0;
      end else if (wb_flush_i) begin
        if (dmem_ack_i) m_busy = 0;
        else m_kill = 1;
      end else if (dmem_ack_i) begin
        m_busy = 0;
        if (dmem_err_i) begin
          e_exc = 1; e_bad = m_addr;
        end else begin
          e_we = (m_rd != 0); e_dst = m_rd; e_d = load_value(dmem_q_i, m_addr, m_sz, m_uns);
        end
      end

      tick();
      chk("rand_we", {31'b0, rf_we_o}, {31'b0, e_we});
      chk("rand_exc", {31'b0, wb_exception_o}, {31'b0, e_exc});
      chk("rand_stall", {31'b0, wb_stall_o}, {31'b0, m_busy});
      if (e_we) begin
        chk("rand_dst", {27'b0, rf_dst_o}, {27'b0, e_dst});
        chk("rand_data", rf_dst_d_o, e_d);
      end
      if (e_exc) chk("rand_bad", wb_badaddr_o, e_bad);
    end

    // Drain any outstanding load with a bounded wait.
    clear_inputs();
    dmem_ack_i = 1;
    to = 0;
    while (wb_stall_o && to < 20) begin
      tick();
      to++;
    end
    dmem_ack_i = 0;
    chk("drain_stall", {31'b0, wb_stall_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
